// File: rtl/edac_arb_pkg.sv
// ============================================================================
//  Module      : edac_arb_pkg
//  Description : Shared types and constants for the EDAC arbiter slice.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package edac_arb_pkg;

    // Operation sequencer states: issue the op, then let the EDAC write back its LUT.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WB    = 2'd2
    } state_e;

    // Word the EDAC emits for an uncorrectable read.
    localparam logic [31:0] C_ERROR_CODE = 32'hFFFF_FFFF;

    // Requester indices into the request/win vectors.
    localparam int C_PORT_A = 0;
    localparam int C_PORT_B = 1;

endpackage

`default_nettype wire

// File: rtl/edac_arbiter_rr_arb2.sv
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-way round-robin arbiter. The pointer remembers the last
//                winner; on contention the other port wins. A lone requester
//                always wins.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2
    import edac_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] win
);

    // 1 = port B won last, 0 = port A won last
    logic last_q;
    logic last_d;

    // Pick the winner; only a tie consults the pointer
    always_comb begin
        win = 2'b00;
        case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = last_q ? 2'b01 : 2'b10;
            default: win = 2'b00;
        endcase
    end

    // Pointer moves only when a grant is actually taken
    always_comb begin
        last_d = last_q;
        if (advance && (win != 2'b00)) begin
            last_d = win[C_PORT_B];
        end
    end

    // Reset value marks B as last winner so A is favoured first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    logic unused_a;
    assign unused_a = win[C_PORT_A];

endmodule

`default_nettype wire

// File: rtl/edac_arbiter.sv
// ============================================================================
//  Module      : edac_arbiter
//  Description : Shares one EDAC block between two requesters. Each op runs
//                ISSUE (en) then WB (EDACSEL write-back); the registered
//                result is returned with a one-cycle ack. Uncorrectable reads
//                are counted in a saturating counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module edac_arbiter
    import edac_arb_pkg::*;
#(
    parameter logic [31:0] ERROR_CODE = C_ERROR_CODE,
    parameter int          CNT_W      = 8
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             req_a,
    input  logic             rd_a,
    input  logic [31:0]      din_a,
    output logic             gnt_a,
    output logic             ack_a,
    input  logic             req_b,
    input  logic             rd_b,
    input  logic [31:0]      din_b,
    output logic             gnt_b,
    output logic             ack_b,
    output logic [31:0]      rsp_data,
    output logic             rsp_err,
    output logic [CNT_W-1:0] err_cnt,
    output logic             edac_en,
    output logic             edac_sel,
    output logic             edac_read,
    output logic [31:0]      edac_din,
    input  logic [31:0]      edac_dout
);

    state_e             state_q, state_d;
    logic               gnt_a_q, gnt_a_d;
    logic               gnt_b_q, gnt_b_d;
    logic               ack_a_q, ack_a_d;
    logic               ack_b_q, ack_b_d;
    logic               edac_en_q, edac_en_d;
    logic               edac_sel_q, edac_sel_d;
    // edac_read/edac_din double as the latched copy of the granted op
    logic               edac_read_q, edac_read_d;
    logic [31:0]        edac_din_q, edac_din_d;
    logic [31:0]        rsp_data_q, rsp_data_d;
    logic               rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic [1:0]         w_win;
    logic               w_advance;
    logic               w_uncorr;

    assign w_advance = (state_q == IDLE);
    assign w_uncorr  = edac_read_q && (edac_dout == ERROR_CODE);

    rr_arb2 u_rr_arb2 (
        .clk     (CLK),
        .rst_n   (reset),
        .req     ({req_b, req_a}),
        .advance (w_advance),
        .win     (w_win)
    );

    // Next-state and next-output computation for the op sequencer
    always_comb begin
        state_d     = state_q;
        gnt_a_d     = gnt_a_q;
        gnt_b_d     = gnt_b_q;
        ack_a_d     = 1'b0;
        ack_b_d     = 1'b0;
        edac_en_d   = edac_en_q;
        edac_sel_d  = edac_sel_q;
        edac_read_d = edac_read_q;
        edac_din_d  = edac_din_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        err_cnt_d   = err_cnt_q;
        case (state_q)
            IDLE: begin
                edac_en_d  = 1'b0;
                edac_sel_d = 1'b0;
                if (w_win != 2'b00) begin
                    gnt_a_d     = w_win[C_PORT_A];
                    gnt_b_d     = w_win[C_PORT_B];
                    edac_en_d   = 1'b1;
                    edac_read_d = w_win[C_PORT_B] ? rd_b  : rd_a;
                    edac_din_d  = w_win[C_PORT_B] ? din_b : din_a;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                edac_en_d  = 1'b0;
                edac_sel_d = 1'b1;
                state_d    = WB;
            end
            WB: begin
                // EDAC output is valid this cycle; capture and complete
                edac_sel_d = 1'b0;
                rsp_data_d = edac_dout;
                rsp_err_d  = w_uncorr;
                ack_a_d    = gnt_a_q;
                ack_b_d    = gnt_b_q;
                gnt_a_d    = 1'b0;
                gnt_b_d    = 1'b0;
                if (w_uncorr && (err_cnt_q != {CNT_W{1'b1}})) begin
                    err_cnt_d = err_cnt_q + 1'b1;
                end
                state_d    = IDLE;
            end
            default: begin
                gnt_a_d    = 1'b0;
                gnt_b_d    = 1'b0;
                edac_en_d  = 1'b0;
                edac_sel_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any op in flight
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            gnt_a_q     <= 1'b0;
            gnt_b_q     <= 1'b0;
            ack_a_q     <= 1'b0;
            ack_b_q     <= 1'b0;
            edac_en_q   <= 1'b0;
            edac_sel_q  <= 1'b0;
            edac_read_q <= 1'b0;
            edac_din_q  <= 32'd0;
            rsp_data_q  <= 32'd0;
            rsp_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            gnt_a_q     <= gnt_a_d;
            gnt_b_q     <= gnt_b_d;
            ack_a_q     <= ack_a_d;
            ack_b_q     <= ack_b_d;
            edac_en_q   <= edac_en_d;
            edac_sel_q  <= edac_sel_d;
            edac_read_q <= edac_read_d;
            edac_din_q  <= edac_din_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign gnt_a     = gnt_a_q;
    assign gnt_b     = gnt_b_q;
    assign ack_a     = ack_a_q;
    assign ack_b     = ack_b_q;
    assign edac_en   = edac_en_q;
    assign edac_sel  = edac_sel_q;
    assign edac_read = edac_read_q;
    assign edac_din  = edac_din_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_edac_arbiter.sv
// ============================================================================
//  Module      : tb_edac_arbiter
//  Description : Self-checking bench for edac_arbiter with a behavioural EDAC
//                stub and a result scoreboard. A second instance with a
//                2-bit counter exercises saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_edac_arbiter;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        reset = 1'b1;
    logic        req_a = 1'b0, rd_a = 1'b0, req_b = 1'b0, rd_b = 1'b0;
    logic [31:0] din_a = 32'd0, din_b = 32'd0;
    logic        stub_force = 1'b0;

    // main instance
    logic        gnt_a, ack_a, gnt_b, ack_b, rsp_err, edac_en, edac_sel, edac_read;
    logic [31:0] rsp_data, edac_din;
    logic [7:0]  err_cnt;
    logic [31:0] dout1 = 32'd0;

    // narrow-counter instance
    logic        gnt_a_s, ack_a_s, gnt_b_s, ack_b_s, rsp_err_s, edac_en_s, edac_sel_s, edac_read_s;
    logic [31:0] rsp_data_s, edac_din_s;
    logic [1:0]  err_cnt_s;
    logic [31:0] dout2 = 32'd0;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic        port;   // 0 = A, 1 = B
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t sb[$];

    function automatic logic [31:0] stub_f(input logic rd, input logic [31:0] x);
        return rd ? (x + 32'h1000_0000) : (x ^ 32'hC0DE_0000);
    endfunction

    // EDAC stubs: output registered on the enable cycle
    always @(posedge CLK) begin
        if (edac_en)   dout1 <= stub_force ? 32'hFFFF_FFFF : stub_f(edac_read, edac_din);
        if (edac_en_s) dout2 <= stub_force ? 32'hFFFF_FFFF : stub_f(edac_read_s, edac_din_s);
    end

    edac_arbiter #(.ERROR_CODE(32'hFFFF_FFFF), .CNT_W(8)) dut (
        .CLK(CLK), .reset(reset),
        .req_a(req_a), .rd_a(rd_a), .din_a(din_a), .gnt_a(gnt_a), .ack_a(ack_a),
        .req_b(req_b), .rd_b(rd_b), .din_b(din_b), .gnt_b(gnt_b), .ack_b(ack_b),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .err_cnt(err_cnt),
        .edac_en(edac_en), .edac_sel(edac_sel), .edac_read(edac_read),
        .edac_din(edac_din), .edac_dout(dout1)
    );

    edac_arbiter #(.ERROR_CODE(32'hFFFF_FFFF), .CNT_W(2)) dut_s (
        .CLK(CLK), .reset(reset),
        .req_a(req_a), .rd_a(rd_a), .din_a(din_a), .gnt_a(gnt_a_s), .ack_a(ack_a_s),
        .req_b(req_b), .rd_b(rd_b), .din_b(din_b), .gnt_b(gnt_b_s), .ack_b(ack_b_s),
        .rsp_data(rsp_data_s), .rsp_err(rsp_err_s), .err_cnt(err_cnt_s),
        .edac_en(edac_en_s), .edac_sel(edac_sel_s), .edac_read(edac_read_s),
        .edac_din(edac_din_s), .edac_dout(dout2)
    );

    // Scoreboard and exclusivity monitor
    always @(negedge CLK) begin
        exp_t e;
        if (reset) begin
            n_cmp++;
            if ({gnt_a & gnt_b, ack_a & ack_b} !== 2'b00) begin
                n_fail++;
                $display("FAIL exclusive: gnt=%b%b ack=%b%b, required not both high", gnt_a, gnt_b, ack_a, ack_b);
            end
            if (ack_a || ack_b) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_ack: ack_a=%b ack_b=%b with empty scoreboard", ack_a, ack_b);
                end else begin
                    e = sb.pop_front();
                    if ({ack_b, rsp_data, rsp_err} !== {e.port, e.data, e.err}) begin
                        n_fail++;
                        $display("FAIL response: got port=%b data=%h err=%b, required port=%b data=%h err=%b",
                                 ack_b, rsp_data, rsp_err, e.port, e.data, e.err);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        #2 reset = 1'b0;
        repeat (2) @(negedge CLK);
        n_cmp++;
        if ({gnt_a, gnt_b, ack_a, ack_b, edac_en, edac_sel, edac_read, rsp_err} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b, required 00000000",
                     {gnt_a, gnt_b, ack_a, ack_b, edac_en, edac_sel, edac_read, rsp_err});
        end
        n_cmp++;
        if ({edac_din, rsp_data} !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_data: got din=%h rsp=%h, required 0", edac_din, rsp_data);
        end
        n_cmp++;
        if (err_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d, required 0", err_cnt);
        end
    endtask

    task automatic test_contention();
        int na = 0;
        int nb = 0;
        logic [1:0] exp_ack;
        req_a = 1'b1; rd_a = 1'b0; din_a = 32'h11;
        req_b = 1'b1; rd_b = 1'b1; din_b = 32'h22;
        sb.push_back('{1'b0, stub_f(1'b0, 32'h11), 1'b0});
        sb.push_back('{1'b1, stub_f(1'b1, 32'h22), 1'b0});
        sb.push_back('{1'b0, stub_f(1'b0, 32'h11), 1'b0});
        sb.push_back('{1'b1, stub_f(1'b1, 32'h22), 1'b0});
        @(negedge CLK);
        reset = 1'b1;                       // cycle 0
        for (int c = 1; c <= 13; c++) begin
            @(negedge CLK);
            exp_ack = {(c == 6 || c == 12), (c == 3 || c == 9)};
            n_cmp++;
            if ({ack_b, ack_a} !== exp_ack) begin
                n_fail++;
                $display("FAIL contention_ack_c%0d: got {b,a}=%b, required %b", c, {ack_b, ack_a}, exp_ack);
            end
            if (ack_a) begin na++; if (na == 2) req_a = 1'b0; end
            if (ack_b) begin nb++; if (nb == 2) req_b = 1'b0; end
        end
        req_a = 1'b0; req_b = 1'b0;
    endtask

    task automatic test_single_write();
        req_a = 1'b1; rd_a = 1'b0; din_a = 32'h0000_0005;
        sb.push_back('{1'b0, stub_f(1'b0, 32'h5), 1'b0});
        @(negedge CLK);                     // cycle 1
        n_cmp++;
        if ({gnt_a, gnt_b, edac_en, edac_sel, edac_read, edac_din} !== {5'b10100, 32'h5}) begin
            n_fail++;
            $display("FAIL write_issue: got gnt=%b%b en=%b sel=%b rd=%b din=%h, required 1 0 1 0 0 00000005",
                     gnt_a, gnt_b, edac_en, edac_sel, edac_read, edac_din);
        end
        @(negedge CLK);                     // cycle 2
        n_cmp++;
        if ({edac_en, edac_sel} !== 2'b01) begin
            n_fail++;
            $display("FAIL write_wb: got en=%b sel=%b, required en=0 sel=1", edac_en, edac_sel);
        end
        @(negedge CLK);                     // cycle 3
        n_cmp++;
        if (ack_a !== 1'b1) begin
            n_fail++;
            $display("FAIL write_ack: got ack_a=%b, required 1", ack_a);
        end
        req_a = 1'b0;
    endtask

    task automatic test_withdraw();
        logic bad = 1'b0;
        req_a = 1'b1; rd_a = 1'b1; din_a = 32'h55;
        sb.push_back('{1'b0, stub_f(1'b1, 32'h55), 1'b0});
        @(negedge CLK);                     // cycle 1
        n_cmp++;
        if ({gnt_a, edac_din} !== {1'b1, 32'h55}) begin
            n_fail++;
            $display("FAIL latch_c1: got gnt_a=%b din=%h, required 1 00000055", gnt_a, edac_din);
        end
        din_a = 32'h99; req_b = 1'b1; rd_b = 1'b0; din_b = 32'h77;
        @(negedge CLK);                     // cycle 2
        n_cmp++;
        if (edac_din !== 32'h55) begin
            n_fail++;
            $display("FAIL latch_c2: got din=%h, required 00000055", edac_din);
        end
        req_b = 1'b0;
        @(negedge CLK);                     // cycle 3
        n_cmp++;
        if (ack_a !== 1'b1) begin
            n_fail++;
            $display("FAIL withdraw_ack_a: got %b, required 1", ack_a);
        end
        req_a = 1'b0;
        repeat (4) begin
            @(negedge CLK);
            bad = bad | gnt_b | ack_b;
        end
        n_cmp++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL withdraw_b: got gnt_b/ack_b activity=%b, required 0", bad);
        end
    endtask

    task automatic test_uncorrectable();
        logic seen;
        stub_force = 1'b1;
        n_cmp++;
        if (err_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL uncorr_pre_cnt: got %0d, required 0", err_cnt);
        end
        req_b = 1'b1; rd_b = 1'b1; din_b = 32'h33;
        sb.push_back('{1'b1, 32'hFFFF_FFFF, 1'b1});
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge CLK);
            if (ack_b) seen = 1'b1;
        end
        req_b = 1'b0;
        n_cmp++;
        if (!seen || err_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL uncorr_read_cnt: got ack=%b cnt=%0d, required ack=1 cnt=1", seen, err_cnt);
        end
        req_a = 1'b1; rd_a = 1'b0; din_a = 32'h66;
        sb.push_back('{1'b0, 32'hFFFF_FFFF, 1'b0});
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge CLK);
            if (ack_a) seen = 1'b1;
        end
        req_a = 1'b0;
        n_cmp++;
        if (!seen || err_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL uncorr_write_cnt: got ack=%b cnt=%0d, required ack=1 cnt=1", seen, err_cnt);
        end
        stub_force = 1'b0;
    endtask

    task automatic test_reset_mid();
        req_a = 1'b1; rd_a = 1'b0; din_a = 32'h44;
        @(negedge CLK);                     // ISSUE
        @(negedge CLK);                     // WB
        n_cmp++;
        if (edac_sel !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_wb: got sel=%b, required 1", edac_sel);
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({gnt_a, edac_sel, edac_en, ack_a, rsp_err, edac_din, rsp_data} !== 69'd0) begin
            n_fail++;
            $display("FAIL mid_async_clear: got gnt=%b sel=%b en=%b ack=%b din=%h, required all 0",
                     gnt_a, edac_sel, edac_en, ack_a, edac_din);
        end
        @(negedge CLK);
        n_cmp++;
        if (ack_a !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_no_ack: got %b, required 0", ack_a);
        end
        reset = 1'b1;
        sb.push_back('{1'b0, stub_f(1'b0, 32'h44), 1'b0});
        @(negedge CLK);
        n_cmp++;
        if ({edac_en, gnt_a, edac_din} !== {2'b11, 32'h44}) begin
            n_fail++;
            $display("FAIL mid_regrant: got en=%b gnt_a=%b din=%h, required 1 1 00000044", edac_en, gnt_a, edac_din);
        end
        repeat (2) @(negedge CLK);
        n_cmp++;
        if (ack_a !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_ack: got %b, required 1", ack_a);
        end
        req_a = 1'b0;
    endtask

    task automatic test_saturation();
        logic seen;
        int unsigned exp_sat [5] = '{1, 2, 3, 3, 3};
        @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        reset = 1'b1;
        stub_force = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req_a = 1'b1; rd_a = 1'b1; din_a = i;
            sb.push_back('{1'b0, 32'hFFFF_FFFF, 1'b1});
            seen = 1'b0;
            for (int k = 0; k < 8 && !seen; k++) begin
                @(negedge CLK);
                if (ack_a) seen = 1'b1;
            end
            n_cmp++;
            if (!seen || err_cnt_s !== exp_sat[i][1:0] || err_cnt !== 8'(i + 1)) begin
                n_fail++;
                $display("FAIL sat_%0d: got ack=%b cnt2=%0d cnt8=%0d, required ack=1 cnt2=%0d cnt8=%0d",
                         i, seen, err_cnt_s, err_cnt, exp_sat[i], i + 1);
            end
        end
        req_a = 1'b0;
        stub_force = 1'b0;
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single_write();
        test_withdraw();
        test_uncorrectable();
        test_reset_mid();
        test_saturation();
        repeat (4) @(negedge CLK);
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Hard time limit so the bench can never hang
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1);
    end

endmodule

`default_nettype wire
